// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial WIDTH-bit adder controller driving a single
// 1-bit full-adder slice, LSB first, with a one-cycle done pulse.
// Optional feature: define SERIAL_ADDER_OVF_EN to add the ovf_o signed-overflow output.
module serial_adder_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf_o
`endif
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             load;
    logic             step;
    logic             last;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic             carry;
    logic [CNT_W-1:0] cnt;

    logic             slice_s;
    logic             slice_c;

    // 1-bit full-adder slice fed from the operand LSBs and the carry register
    assign slice_s = a_sh[0] ^ b_sh[0] ^ carry;
    assign slice_c = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);

    // State register
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and datapath control decode; start is ignored while in RUN
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        last      = 1'b0;
        case (state)
            IDLE: begin
                if (start_i) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (cnt == LAST_CNT) begin
                    last      = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (start_i) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand/sum shift registers, carry register and bit counter
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
        end else if (load) begin
            a_sh  <= a_i;
            b_sh  <= b_i;
            carry <= cin_i;
            cnt   <= '0;
        end else if (step) begin
            a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
            b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
            sum_sh <= {slice_s, sum_sh[WIDTH-1:1]};
            carry  <= slice_c;
            cnt    <= cnt + CNT_W'(1);
        end
    end

    // Result registers update only on the final RUN edge and hold otherwise
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sum_o  <= '0;
            cout_o <= 1'b0;
        end else if (last) begin
            sum_o  <= {slice_s, sum_sh[WIDTH-1:1]};
            cout_o <= slice_c;
        end
    end

`ifdef SERIAL_ADDER_OVF_EN
    // Signed overflow: carry into the MSB differs from the carry out of it
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            ovf_o <= 1'b0;
        end else if (last) begin
            ovf_o <= carry ^ slice_c;
        end
    end
`endif

    // Status flags registered from the next state so they track the FSM
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            busy_o <= 1'b0;
            done_o <= 1'b0;
        end else begin
            busy_o <= (state_nxt != IDLE);
            done_o <= (state_nxt == DONE);
        end
    end

endmodule
